cail_param_arbiter: RTL and testbench

Shares the single IIC calibration-parameter controller (`cail_param_control`) among `N_REQ` channel requesters. Each requester posts a read or write of one 32-bit calibration word. The arbiter holds off all traffic for a fixed power-up window, then grants requesters round-robin, one transaction at a time. It sequences the controller's `wr_req`/`rd_req` pulses, waits for completion or timeout, and returns data or error to the winner.

---
 rtl/cail_pkg.sv | 16 +
 rtl/cail_rr_pick.sv | 28 ++
 rtl/cail_param_arbiter.sv | 154 +++++++++++++++
 tb/tb_cail_param_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cail_pkg.sv
// Shared state encoding and default timing constants for the
// calibration-parameter arbiter.
package cail_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } cail_state_t;

  localparam int CAIL_INIT_WAIT = 29;
  localparam int CAIL_TIMEOUT   = 65535;

endpackage

// File: rtl/cail_rr_pick.sv
// Combinational round-robin picker: the search starts one past the
// previous winner and wraps around the request vector.
module cail_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] winner,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    cand   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(last) + k) % N_REQ);
      if (!any && req[cand]) begin
        any    = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/cail_param_arbiter.sv
// Shares one calibration-parameter controller among N_REQ requesters,
// one transaction at a time, after a fixed power-up hold-off window.
module cail_param_arbiter
  import cail_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int INIT_WAIT = CAIL_INIT_WAIT,
  parameter int TIMEOUT   = CAIL_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_we,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [N_REQ-1:0]         rsp_err,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     ctl_wr_req,
  output logic                     ctl_rd_req,
  output logic [ADDR_W-1:0]        ctl_wr_addr,
  output logic [ADDR_W-1:0]        ctl_rd_addr,
  output logic [DATA_W-1:0]        ctl_wr_data,
  input  logic [DATA_W-1:0]        ctl_rd_data,
  input  logic                     ctl_done,
  output logic                     busy
);

  localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int INIT_CW = $clog2(INIT_WAIT + 2);
  localparam int TO_CW   = $clog2(TIMEOUT + 2);

  cail_state_t        state;
  logic [INIT_CW-1:0] init_cnt;
  logic [TO_CW-1:0]   wait_cnt;
  logic [IDX_W-1:0]   last;
  logic [IDX_W-1:0]   lat_idx;
  logic               lat_we;
  logic [ADDR_W-1:0]  lat_addr;
  logic [DATA_W-1:0]  lat_wdata;

  logic [IDX_W-1:0]   pick;
  logic               pick_any;
  logic [N_REQ-1:0]   pick_oh;
  logic [N_REQ-1:0]   lat_oh;
  logic [ADDR_W-1:0]  addr_arr  [N_REQ];
  logic [DATA_W-1:0]  wdata_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
  end

  cail_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req_valid),
    .last   (last),
    .winner (pick),
    .any    (pick_any)
  );

  assign pick_oh = N_REQ'(1) << pick;
  assign lat_oh  = N_REQ'(1) << lat_idx;

  // Controller address/data come straight from the latched request so they
  // hold steady for the whole ISSUE..RESP window.
  assign ctl_wr_addr = lat_addr;
  assign ctl_rd_addr = lat_addr;
  assign ctl_wr_data = lat_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_INIT;
      init_cnt   <= '0;
      wait_cnt   <= '0;
      last       <= IDX_W'(N_REQ - 1);
      lat_idx    <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_err    <= '0;
      rsp_rdata  <= '0;
      ctl_wr_req <= 1'b0;
      ctl_rd_req <= 1'b0;
      busy       <= 1'b0;
    end else begin
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_err    <= '0;
      rsp_rdata  <= '0;
      ctl_wr_req <= 1'b0;
      ctl_rd_req <= 1'b0;
      case (state)
        ST_INIT: begin
          if (init_cnt == INIT_CW'(INIT_WAIT)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            init_cnt <= init_cnt + 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_IDLE: begin
          busy <= 1'b0;
          if (pick_any) begin
            state      <= ST_ISSUE;
            busy       <= 1'b1;
            lat_idx    <= pick;
            lat_we     <= req_we[pick];
            lat_addr   <= addr_arr[pick];
            lat_wdata  <= wdata_arr[pick];
            req_ready  <= pick_oh;
            ctl_wr_req <= req_we[pick];
            ctl_rd_req <= !req_we[pick];
            wait_cnt   <= '0;
          end
        end
        ST_ISSUE: begin
          last  <= lat_idx;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done pulse in the timeout cycle still counts as success.
          if (ctl_done) begin
            state     <= ST_RESP;
            rsp_valid <= lat_oh;
            rsp_rdata <= lat_we ? '0 : ctl_rd_data;
          end else if (wait_cnt == TO_CW'(TIMEOUT)) begin
            state     <= ST_RESP;
            rsp_valid <= lat_oh;
            rsp_err   <= lat_oh;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cail_param_arbiter.sv
// Directed, table-driven bench for cail_param_arbiter with a hand-driven
// controller model (ctl_done / ctl_rd_data).
module tb_cail_param_arbiter;

  localparam int N_REQ     = 4;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 32;
  localparam int INIT_WAIT = 29;
  localparam int TIMEOUT   = 100;
  localparam int N_VEC     = 6;

  logic                    clk;
  logic                    rst;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_we;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ-1:0]        rsp_err;
  logic [DATA_W-1:0]       rsp_rdata;
  logic                    ctl_wr_req;
  logic                    ctl_rd_req;
  logic [ADDR_W-1:0]       ctl_wr_addr;
  logic [ADDR_W-1:0]       ctl_rd_addr;
  logic [DATA_W-1:0]       ctl_wr_data;
  logic [DATA_W-1:0]       ctl_rd_data;
  logic                    ctl_done;
  logic                    busy;

  int checks = 0;
  int errors = 0;

  // delay = WAIT cycles before ctl_done (-1 = never); issue_done pulses a
  // stray ctl_done during the ISSUE cycle.
  typedef struct {
    int          idx;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          delay;
    logic        issue_done;
    logic [31:0] ctl_rdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [N_VEC];

  cail_param_arbiter #(
    .N_REQ     (N_REQ),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .INIT_WAIT (INIT_WAIT),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_err     (rsp_err),
    .rsp_rdata   (rsp_rdata),
    .ctl_wr_req  (ctl_wr_req),
    .ctl_rd_req  (ctl_rd_req),
    .ctl_wr_addr (ctl_wr_addr),
    .ctl_rd_addr (ctl_rd_addr),
    .ctl_wr_data (ctl_wr_data),
    .ctl_rd_data (ctl_rd_data),
    .ctl_done    (ctl_done),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: no finish by time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(input int idx, input logic we, input logic [7:0] addr,
                                 input logic [31:0] wdata, input int delay, input logic issue_done,
                                 input logic [31:0] ctl_rdata, input logic [31:0] exp_rdata,
                                 input logic exp_err);
    vec_t v;
    v.idx = idx; v.we = we; v.addr = addr; v.wdata = wdata; v.delay = delay;
    v.issue_done = issue_done; v.ctl_rdata = ctl_rdata; v.exp_rdata = exp_rdata;
    v.exp_err = exp_err;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic waitReady(input int bound, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (req_ready == '0 && lat < bound);
  endtask

  task automatic applyStimulus(input int n, input vec_t v);
    logic [N_REQ-1:0] oh;
    int lat;
    int k;
    int exp_k;
    bit unstable;
    bit got;
    oh = N_REQ'(1) << v.idx;
    req_we[v.idx] = v.we;
    req_addr[v.idx*ADDR_W +: ADDR_W] = v.addr;
    req_wdata[v.idx*DATA_W +: DATA_W] = v.wdata;
    req_valid = oh;
    waitReady(8, lat);
    checkOutput($sformatf("v%0d ready latency", n), 32'(lat), 32'd1);
    checkOutput($sformatf("v%0d req_ready", n), 32'(req_ready), 32'(oh));
    checkOutput($sformatf("v%0d ctl_wr_req", n), 32'(ctl_wr_req), 32'(v.we));
    checkOutput($sformatf("v%0d ctl_rd_req", n), 32'(ctl_rd_req), 32'(!v.we));
    checkOutput($sformatf("v%0d ctl_rd_addr", n), 32'(ctl_rd_addr), 32'(v.addr));
    checkOutput($sformatf("v%0d ctl_wr_data", n), ctl_wr_data, v.wdata);
    req_valid = '0;
    ctl_done = v.issue_done;
    ctl_rd_data = 32'h5555_5555;
    tick();
    ctl_done = 1'b0;
    k = 0;
    got = 0;
    unstable = 0;
    while (!got && k < TIMEOUT + 20) begin
      if (ctl_wr_addr !== v.addr || ctl_rd_addr !== v.addr || ctl_wr_data !== v.wdata ||
          ctl_wr_req !== 1'b0 || ctl_rd_req !== 1'b0 || req_ready !== '0 || busy !== 1'b1)
        unstable = 1;
      if (k == v.delay) begin
        ctl_done = 1'b1;
        ctl_rd_data = v.ctl_rdata;
      end
      tick();
      ctl_done = 1'b0;
      ctl_rd_data = 32'h5555_5555;
      k++;
      if (rsp_valid !== '0) got = 1;
    end
    exp_k = (v.delay >= 0) ? v.delay + 1 : TIMEOUT + 1;
    checkOutput($sformatf("v%0d wait stable", n), 32'(unstable), 32'd0);
    checkOutput($sformatf("v%0d rsp cycle", n), 32'(k), 32'(exp_k));
    checkOutput($sformatf("v%0d rsp_valid", n), 32'(rsp_valid), 32'(oh));
    checkOutput($sformatf("v%0d rsp_err", n), 32'(rsp_err), v.exp_err ? 32'(oh) : 32'd0);
    checkOutput($sformatf("v%0d rsp_rdata", n), rsp_rdata, v.exp_rdata);
    checkOutput($sformatf("v%0d resp addr", n), 32'(ctl_wr_addr), 32'(v.addr));
    tick();
    checkOutput($sformatf("v%0d idle busy", n), {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    logic [N_REQ-1:0] oh;

    rst = 1'b1;
    req_valid = 4'b0001;
    req_we = '0;
    req_addr = '0;
    req_wdata = '0;
    ctl_done = 1'b0;
    ctl_rd_data = '0;
    req_addr[7:0] = 8'h11;

    vecs[0] = mkVec(2, 1'b0, 8'h15, 32'h2222_0000, 39, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    vecs[1] = mkVec(1, 1'b1, 8'h3C, 32'h1234_5678, 5, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0);
    vecs[2] = mkVec(3, 1'b0, 8'h7E, 32'h3333_0000, -1, 1'b0, 32'h0, 32'h0, 1'b1);
    vecs[3] = mkVec(0, 1'b0, 8'h01, 32'h4444_0000, 0, 1'b0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0);
    vecs[4] = mkVec(1, 1'b0, 8'h44, 32'h5151_0000, 3, 1'b1, 32'h600D_CAFE, 32'h600D_CAFE, 1'b0);
    vecs[5] = mkVec(3, 1'b0, 8'h9A, 32'h6666_0000, TIMEOUT, 1'b0, 32'hCAFE_0001, 32'hCAFE_0001, 1'b0);

    repeat (2) @(negedge clk);
    checkOutput("reset outputs", {17'd0, busy, ctl_wr_req, ctl_rd_req, req_ready, rsp_valid, rsp_err}, 32'd0);

    // Power-up hold-off with requester 0 already waiting.
    rst = 1'b0;
    waitReady(INIT_WAIT + 10, lat);
    checkOutput("init first ready cycle", 32'(lat), 32'(INIT_WAIT + 2));
    checkOutput("init req_ready", 32'(req_ready), 32'h1);
    checkOutput("init ctl_rd_req", 32'(ctl_rd_req), 32'h1);
    checkOutput("init ctl_rd_addr", 32'(ctl_rd_addr), 32'h11);
    req_valid = '0;
    tick();
    ctl_done = 1'b1;
    ctl_rd_data = 32'hA5A5_0000;
    tick();
    ctl_done = 1'b0;
    checkOutput("init rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("init rsp_rdata", rsp_rdata, 32'hA5A5_0000);
    tick();

    for (int i = 0; i < N_VEC; i++) applyStimulus(i, vecs[i]);

    // Everyone valid: strict rotation starting after the last grant (3).
    req_we = '0;
    req_valid = '1;
    for (int g = 0; g < 8; g++) begin
      oh = N_REQ'(1) << (g % N_REQ);
      waitReady(6, lat);
      checkOutput($sformatf("rr grant %0d", g), 32'(req_ready), 32'(oh));
      tick();
      ctl_done = 1'b1;
      ctl_rd_data = 32'h100 + 32'(g);
      tick();
      ctl_done = 1'b0;
      if (g == 7) req_valid = '0;
      checkOutput($sformatf("rr rsp_valid %0d", g), 32'(rsp_valid), 32'(oh));
      checkOutput($sformatf("rr rsp_rdata %0d", g), rsp_rdata, 32'h100 + 32'(g));
    end
    tick();

    // Asynchronous reset in the middle of a WAIT.
    req_addr[2*ADDR_W +: ADDR_W] = 8'h5A;
    req_wdata[2*DATA_W +: DATA_W] = 32'h8765_4321;
    req_we[2] = 1'b1;
    req_valid = 4'b0100;
    waitReady(6, lat);
    checkOutput("mid-wait grant", 32'(req_ready), 32'h4);
    req_valid = '0;
    repeat (3) tick();
    checkOutput("mid-wait busy", {31'd0, busy}, 32'd1);
    checkOutput("mid-wait addr", 32'(ctl_wr_addr), 32'h5A);
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset flags", {17'd0, busy, ctl_wr_req, ctl_rd_req, req_ready, rsp_valid, rsp_err}, 32'd0);
    checkOutput("async reset addr", 32'(ctl_wr_addr), 32'd0);
    checkOutput("async reset wdata", ctl_wr_data, 32'd0);
    req_valid = '1;
    @(negedge clk);
    rst = 1'b0;
    waitReady(INIT_WAIT + 10, lat);
    checkOutput("post-reset ready cycle", 32'(lat), 32'(INIT_WAIT + 2));
    checkOutput("post-reset grant", 32'(req_ready), 32'h1);
    checkOutput("post-reset ctl_rd_req", 32'(ctl_rd_req), 32'h1);
    req_valid = '0;
    tick();
    ctl_done = 1'b1;
    ctl_rd_data = 32'h7777_0000;
    tick();
    ctl_done = 1'b0;
    checkOutput("post-reset rsp_valid", 32'(rsp_valid), 32'h1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
